// File: rtl/snake_pkg.sv
// snake_pkg: direction encodings, button indices and the reversal test shared by the snake input path.
package snake_pkg;
  typedef logic [1:0] dir_t;
  localparam dir_t DIR_UP    = 2'b00;
  localparam dir_t DIR_DOWN  = 2'b01;
  localparam dir_t DIR_LEFT  = 2'b10;
  localparam dir_t DIR_RIGHT = 2'b11;
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_START = 4;
  function automatic logic is_reverse(dir_t a, dir_t b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction
endpackage

// File: rtl/snake_debounce.sv
// snake_debounce: two-flop synchroniser plus stability counter producing one clean button level.
module snake_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic s1, s2;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) cnt <= '0;
      else if (cnt == LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/snake_input_conditioner.sv
// snake_input_conditioner: debounces raw buttons and turns press edges into a safe direction and start pulse.
module snake_input_conditioner
  import snake_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 250000,
  parameter logic [1:0] RESET_DIR       = 2'b11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_start,
  input  logic       move_tick,
  output logic [1:0] direction,
  output logic       start,
  output logic       dir_changed,
  output logic [4:0] btn_level
);
  logic [4:0] raw, level_d, press;
  dir_t last_moved_dir, cand, next_dir, next_last;
  logic accept;
  assign raw = {btn_start, btn_right, btn_left, btn_down, btn_up};
  for (genvar g = 0; g < 5; g++) begin : g_db
    snake_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk  (clk),
      .reset(reset),
      .raw  (raw[g]),
      .level(btn_level[g])
    );
  end
  assign start = press[BTN_START];
  always_comb begin
    cand = press[BTN_UP]   ? DIR_UP   :
           press[BTN_DOWN] ? DIR_DOWN :
           press[BTN_LEFT] ? DIR_LEFT : DIR_RIGHT;
    // Reversal is judged against the last direction the snake actually moved in.
    accept    = (|press[BTN_RIGHT:BTN_UP]) && !is_reverse(cand, last_moved_dir);
    next_dir  = press[BTN_START] ? RESET_DIR : accept ? cand : direction;
    next_last = press[BTN_START] ? RESET_DIR : move_tick ? direction : last_moved_dir;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_d        <= '0;
      press          <= '0;
      direction      <= RESET_DIR;
      last_moved_dir <= RESET_DIR;
      dir_changed    <= 1'b0;
    end else begin
      level_d        <= btn_level;
      press          <= btn_level & ~level_d;
      direction      <= next_dir;
      last_moved_dir <= next_last;
      dir_changed    <= next_dir != direction;
    end
  end
endmodule
